led_scan_ctrl: RTL
==================

# led_scan_ctrl

Scan controller for the 4-digit multiplexed seven-segment display. It generates the one-hot digit select that drives the digit-data selector and the digit anodes, with programmable dwell and inter-digit blanking to suppress ghosting. It also holds a shadow copy of the display data and dot bits, updated only at frame boundaries so a displayed frame never tears. It sits between the system logic producing display values and the selector/segment decoder.

## Interface

Parameters:
- DWELL_CYCLES, 50000 — clock cycles each digit is driven per slot; legal range ≥1.
- BLANK_CYCLES, 500 — clock cycles with all digits off after each dwell; legal range ≥0, where 0 means no blanking.

Ports:
- clk_in  input  1  system clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- enable_in  input  1  level; 1 = scanning, 0 = display off.
- update_in  input  1  single-cycle strobe; samples ledData_in and ledDot_in into staging.
- ledData_in  input  16  four nibbles; [15:12] is digit 0 and [3:0] is digit 3.
- ledDot_in  input  4  dot bits; [3] is digit 0 and [0] is digit 3.
- digitEn_in  input  4  per-digit enable; bit i = digit i, i.e. select_out bit i.
- select_out  output  4  one-hot digit select; 4'b0001 = digit 0; 4'b0000 = all off.
- ledDataLatched_out  output  16  shadow data presented to the selector.
- ledDotLatched_out  output  4  shadow dot bits presented to the selector.
- frameDone_out  output  1  one-cycle pulse at each frame boundary.
- busy_out  output  1  1 while not in IDLE.

## Operation

States:
- IDLE: select_out = 0, digit index = 0, counter = 0.
- SHOW: select_out = one-hot(index) if digitEn_in[index] = 1, else 0.
- BLANK: select_out = 0.

Transitions:
- IDLE → SHOW(index 0) on the first edge with enable_in = 1.
- SHOW counts 0..DWELL_CYCLES-1. At the last count it goes to BLANK if BLANK_CYCLES > 0. Otherwise it goes straight to SHOW(index+1).
- BLANK counts 0..BLANK_CYCLES-1, then goes to SHOW(index+1).
- The index wraps 3 → 0. The wrap is the frame boundary.
- Any state → IDLE on the first edge with enable_in = 0. This aborts mid-slot with no frameDone_out pulse. Re-enable always restarts at digit 0.

Slot timing:
- A disabled digit still consumes its full slot, so the refresh rate stays constant.
- digitEn_in is sampled every cycle during SHOW.

Data path:
- The counter is sized to the larger of DWELL_CYCLES and BLANK_CYCLES. Counter and index wrap arithmetic is unsigned; the index is 2 bits.
- update_in loads a staging register and sets a pending flag. A later update_in before the boundary overwrites staging (last-wins).
- At a frame boundary with pending set, the shadow registers load from staging and pending clears.
- update_in on the boundary cycle itself: the shadow loads directly from ledData_in/ledDot_in on that edge. Pending is left clear.
- update_in while in IDLE: the shadow loads on the next edge. No boundary wait.

Reset values:
- select_out = 0, ledDataLatched_out = 16'h0000, ledDotLatched_out = 0, frameDone_out = 0, busy_out = 0.
- State = IDLE, staging = 0, pending = 0.

## Timing

- All outputs are registered; there is no combinational path from any input to any output.
- Enable latency: enable_in rises before edge E; select_out = 4'b0001 from edge E.
- Frame length: 4 × (DWELL_CYCLES + BLANK_CYCLES) cycles.
- Boundary pulse: frameDone_out is high for exactly the one cycle in which digit 0 of the new frame first shows. The shadow registers change on that same edge.
- Disable latency: enable_in falls before edge E; select_out = 0 and busy_out = 0 from edge E.
- Asynchronous reset takes effect immediately, with no clock needed, including mid-slot. The first scan after reset release requires enable_in = 1 at a clock edge.

## Test plan

1. **Basic scan.** Parameters DWELL=4, BLANK=1; enable_in held at 1 from cycle 0. Required: select_out = 0001 ×4, 0 ×1, 0010 ×4, 0, 0100 ×4, 0, 1000 ×4, 0. Then frameDone_out pulses together with 0001 at cycle 21.
2. **No blanking.** Parameter BLANK=0, DWELL=2. Required: select_out is 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, then repeats; it is never 0.
3. **Tear-free update.** Issue update_in with data 16'h1234, dots 4'b1000 during digit 1. Required: ledDataLatched_out stays at its old value until the boundary cycle, then becomes 16'h1234 exactly when frameDone_out is 1. Two updates in one frame (16'hAAAA then 16'h5555) → 16'h5555 is latched.
4. **Update on boundary.** Assert update_in with 16'hBEEF on the cycle before frameDone_out. Required: 16'hBEEF is latched on the boundary edge, and no second load happens at the next boundary.
5. **Digit mask.** digitEn_in = 4'b0101. Required: select_out shows 0001 and 0100 in their slots and 0 in the digit 1 and digit 3 slots; the frame length is unchanged.
6. **Abort and reset.** Drop enable_in during digit 2: select_out = 0 next edge, with no frameDone_out pulse; re-enabling starts at 0001. Assert rst_in mid-dwell: all outputs go to their reset values immediately, without a clock edge.

Source files
------------

// File: rtl/led_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with dwell/blank timing
// and a frame-synchronous shadow copy of the display data.
module led_scan_ctrl #(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic        update_in,
  input  logic [15:0] ledData_in,
  input  logic [3:0]  ledDot_in,
  input  logic [3:0]  digitEn_in,
  output logic [3:0]  select_out,
  output logic [15:0] ledDataLatched_out,
  output logic [3:0]  ledDotLatched_out,
  output logic        frameDone_out,
  output logic        busy_out
);

  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int DL   = DWELL_CYCLES - 1;
  localparam int BL   = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    sel_q, sel_d;
  logic [15:0]   data_q, data_d, stg_data_q, stg_data_d;
  logic [3:0]    dot_q, dot_d, stg_dot_q, stg_dot_d;
  logic          pend_q, pend_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          wrap;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CW'(1);
    wrap    = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d = 2'd0;
        cnt_d = '0;
        state_d = SHOW;
      end
      SHOW: begin
        if (cnt_q == CW'(DL)) begin
          cnt_d = '0;
          if (BLANK_CYCLES > 0) begin
            state_d = BLANK;
          end else begin
            idx_d = idx_q + 2'd1;
            wrap  = (idx_q == 2'd3);
          end
        end
      end
      BLANK: begin
        if (cnt_q == CW'(BL)) begin
          cnt_d   = '0;
          state_d = SHOW;
          idx_d   = idx_q + 2'd1;
          wrap    = (idx_q == 2'd3);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Disable wins over everything and aborts the frame without a boundary.
    if (!enable_in) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      cnt_d   = '0;
      wrap    = 1'b0;
    end

    sel_d  = (state_d == SHOW && digitEn_in[idx_d]) ? 4'(4'b0001 << idx_d) : 4'b0000;
    done_d = wrap;
    busy_d = (state_d != IDLE);

    stg_data_d = stg_data_q;
    stg_dot_d  = stg_dot_q;
    pend_d     = pend_q;
    data_d     = data_q;
    dot_d      = dot_q;
    if (update_in) begin
      stg_data_d = ledData_in;
      stg_dot_d  = ledDot_in;
      pend_d     = 1'b1;
    end
    // Shadow may only change while nothing is shown or as a new frame starts.
    if (state_q == IDLE || wrap) begin
      if (update_in) begin
        data_d = ledData_in;
        dot_d  = ledDot_in;
        pend_d = 1'b0;
      end else if (pend_q) begin
        data_d = stg_data_q;
        dot_d  = stg_dot_q;
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      cnt_q      <= '0;
      sel_q      <= 4'b0000;
      data_q     <= 16'h0000;
      dot_q      <= 4'b0000;
      stg_data_q <= 16'h0000;
      stg_dot_q  <= 4'b0000;
      pend_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      dot_q      <= dot_d;
      stg_data_q <= stg_data_d;
      stg_dot_q  <= stg_dot_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign select_out         = sel_q;
  assign ledDataLatched_out = data_q;
  assign ledDotLatched_out  = dot_q;
  assign frameDone_out      = done_q;
  assign busy_out           = busy_q;

endmodule
